// File: rtl/debug_ocimem_arbiter.sv
// Single-port OCI RAM arbiter between the JTAG debug path and the CPU
// Avalon debug_mem_slave. One access in flight at a time. The CPU wins
// ties except after MAX_CPU_RUN back-to-back wins while JTAG is waiting.
module debug_ocimem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 2,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jtag_set_addr,
    input  logic [ADDR_W-1:0]   jtag_addr,
    input  logic                jtag_rd,
    input  logic                jtag_wr,
    input  logic [DATA_W-1:0]   jtag_wdata,
    output logic [DATA_W-1:0]   jtag_rdata,
    output logic                jtag_rdata_valid,
    output logic                jtag_busy,
    output logic                jtag_overrun,
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [DATA_W-1:0]   cpu_writedata,
    input  logic [DATA_W/8-1:0] cpu_byteenable,
    output logic                cpu_waitrequest,
    output logic [DATA_W-1:0]   cpu_readdata,
    output logic                cpu_readdatavalid,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wren,
    output logic [DATA_W/8-1:0] ram_byteen,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_CPU_RUN + 1);
    localparam int LAT_W = 3;

    typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_RET} state_t;

    state_t              state_reg;
    logic                owner_jtag_reg;
    logic [LAT_W-1:0]    wait_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic                pend_reg;
    logic                pend_wr_reg;
    logic [DATA_W-1:0]   pend_wdata_reg;
    logic                overrun_reg;
    logic [CNT_W-1:0]    run_reg;
    logic [ADDR_W-1:0]   ram_addr_reg;
    logic                ram_wren_reg;
    logic [BE_W-1:0]     ram_byteen_reg;
    logic [DATA_W-1:0]   ram_wdata_reg;
    logic [DATA_W-1:0]   jtag_rdata_reg;
    logic                jtag_rdv_reg;
    logic [DATA_W-1:0]   cpu_rdata_reg;
    logic                cpu_rdv_reg;

    logic                idle;
    logic                cpu_req;
    logic                cpu_gnt;
    logic                jtag_gnt;
    logic                busy;
    logic                strobe;
    logic [ADDR_W-1:0]   eff_ptr;
    logic [ADDR_W-1:0]   grant_addr;
    logic [DATA_W-1:0]   grant_wdata;
    logic [BE_W-1:0]     grant_be;
    logic                grant_wr;

    // A set_addr takes effect before any access decided in the same cycle.
    assign eff_ptr  = jtag_set_addr ? jtag_addr : ptr_reg;
    assign idle     = (state_reg == IDLE);
    assign cpu_req  = cpu_read | cpu_write;
    assign cpu_gnt  = idle & cpu_req &
                      ~(pend_reg & (run_reg == CNT_W'(MAX_CPU_RUN)));
    assign jtag_gnt = idle & pend_reg & ~cpu_gnt;
    assign busy     = pend_reg | (~idle & owner_jtag_reg);
    assign strobe   = jtag_rd | jtag_wr;

    assign grant_addr  = cpu_gnt ? cpu_address   : eff_ptr;
    assign grant_wdata = cpu_gnt ? cpu_writedata : pend_wdata_reg;
    assign grant_wr    = cpu_gnt ? cpu_write     : pend_wr_reg;

    // JTAG writes are always full-word; CPU writes use its byte enables.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
            assign grant_be[gi] = cpu_gnt ? cpu_byteenable[gi] : 1'b1;
        end
    endgenerate

    // Access sequencer: issue, wait out RAM latency, return data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_jtag_reg <= 1'b0;
            wait_reg       <= '0;
            ram_addr_reg   <= '0;
            ram_wren_reg   <= 1'b0;
            ram_byteen_reg <= '0;
            ram_wdata_reg  <= '0;
            jtag_rdata_reg <= '0;
            jtag_rdv_reg   <= 1'b0;
            cpu_rdata_reg  <= '0;
            cpu_rdv_reg    <= 1'b0;
        end else begin
            ram_wren_reg <= 1'b0;
            jtag_rdv_reg <= 1'b0;
            cpu_rdv_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_gnt | jtag_gnt) begin
                        ram_addr_reg   <= grant_addr;
                        owner_jtag_reg <= jtag_gnt;
                        if (grant_wr) begin
                            ram_wren_reg   <= 1'b1;
                            ram_byteen_reg <= grant_be;
                            ram_wdata_reg  <= grant_wdata;
                            state_reg      <= WR_ISSUE;
                        end else begin
                            state_reg <= RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: state_reg <= IDLE;
                RD_ISSUE: begin
                    if (RAM_LATENCY == 1) begin
                        state_reg <= RD_RET;
                    end else begin
                        wait_reg  <= LAT_W'(RAM_LATENCY - 2);
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_reg == '0) state_reg <= RD_RET;
                    else                wait_reg  <= wait_reg - 1'b1;
                end
                RD_RET: begin
                    if (owner_jtag_reg) begin
                        jtag_rdata_reg <= ram_rdata;
                        jtag_rdv_reg   <= 1'b1;
                    end else begin
                        cpu_rdata_reg <= ram_rdata;
                        cpu_rdv_reg   <= 1'b1;
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // JTAG pointer, one-deep pending op, overrun flag and CPU run counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg        <= '0;
            pend_reg       <= 1'b0;
            pend_wr_reg    <= 1'b0;
            pend_wdata_reg <= '0;
            overrun_reg    <= 1'b0;
            run_reg        <= '0;
        end else begin
            ptr_reg <= jtag_gnt ? eff_ptr + 1'b1 : eff_ptr;
            if (jtag_gnt) pend_reg <= 1'b0;
            if (strobe & ~busy) begin
                pend_reg       <= 1'b1;
                pend_wr_reg    <= jtag_wr;
                pend_wdata_reg <= jtag_wdata;
            end
            if ((strobe & busy) | (jtag_rd & jtag_wr)) overrun_reg <= 1'b1;
            else if (jtag_set_addr)                    overrun_reg <= 1'b0;
            if (~pend_reg | jtag_gnt) run_reg <= '0;
            else if (cpu_gnt)         run_reg <= run_reg + 1'b1;
        end
    end

    assign cpu_waitrequest   = reset | ~cpu_gnt;
    assign jtag_busy         = busy;
    assign jtag_overrun      = overrun_reg;
    assign jtag_rdata        = jtag_rdata_reg;
    assign jtag_rdata_valid  = jtag_rdv_reg;
    assign cpu_readdata      = cpu_rdata_reg;
    assign cpu_readdatavalid = cpu_rdv_reg;
    assign ram_addr          = ram_addr_reg;
    assign ram_wren          = ram_wren_reg;
    assign ram_byteen        = ram_byteen_reg;
    assign ram_wdata         = ram_wdata_reg;
endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Bench for debug_ocimem_arbiter: a transaction-timeline model predicts
// every cycle's outputs; directed scenarios plus a randomized mix.
module tb_debug_ocimem_arbiter;
    localparam int L   = 2;
    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jtag_set_addr = 1'b0;
    logic [7:0]  jtag_addr = '0;
    logic        jtag_rd = 1'b0;
    logic        jtag_wr = 1'b0;
    logic [31:0] jtag_wdata = '0;
    logic [31:0] jtag_rdata;
    logic        jtag_rdata_valid;
    logic        jtag_busy;
    logic        jtag_overrun;
    logic [7:0]  cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [3:0]  cpu_byteenable = '0;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32), .RAM_LATENCY(L),
                           .MAX_CPU_RUN(MAX)) dut (
        .clk(clk), .reset(reset),
        .jtag_set_addr(jtag_set_addr), .jtag_addr(jtag_addr),
        .jtag_rd(jtag_rd), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
        .jtag_rdata(jtag_rdata), .jtag_rdata_valid(jtag_rdata_valid),
        .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
        .cpu_readdatavalid(cpu_readdatavalid),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM with L-cycle read latency.
    logic [31:0] ram_mem [256] = '{default: 32'h0};
    logic [7:0]  apipe [L] = '{default: 8'h0};
    always @(posedge clk) begin
        if (ram_wren)
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        apipe[0] <= ram_addr;
        for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
    assign ram_rdata = ram_mem[apipe[L-1]];

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the single access in flight is a record with its grant cycle;
    // all timing follows from that cycle.
    int          cyc = 0, free_at = 0, rec_t = 0, m_last_jgnt = 0, m_run = 0;
    bit          rec_valid = 0, rec_write = 0, rec_jtag = 0;
    logic [7:0]  rec_addr = '0;
    logic [3:0]  rec_be = '0;
    logic [31:0] rec_data = '0;
    bit          m_pend = 0, m_pend_wr = 0, m_ov = 0;
    logic [31:0] m_pend_wdata = '0;
    logic [7:0]  m_ptr = '0;
    logic [31:0] m_cpu_hold = '0, m_jtag_hold = '0;
    logic [31:0] shadow [256] = '{default: 32'h0};

    logic [31:0] jq[$], cq[$];
    logic [7:0]  jaddr_q[$], waddr_q[$];
    int          jlat_q[$];
    byte         glog[$];
    int          wr_low_cnt = 0, cpv_cnt = 0;

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit idle, jinfl, busy, creq, cgnt, jgnt, exp_wr, exp_rdi, exp_cv, exp_jv, ovt;
        logic [7:0] eff;
        idle    = (cyc >= free_at);
        jinfl   = rec_valid && rec_jtag && (cyc < free_at);
        busy    = m_pend || jinfl;
        creq    = (cpu_read === 1'b1) || (cpu_write === 1'b1);
        cgnt    = idle && creq && !(m_pend && m_run == MAX);
        jgnt    = idle && m_pend && !cgnt;
        exp_wr  = rec_valid && rec_write && (cyc == rec_t + 1);
        exp_rdi = rec_valid && !rec_write && (cyc == rec_t + 1);
        exp_cv  = rec_valid && !rec_write && !rec_jtag && (cyc == rec_t + 2 + L);
        exp_jv  = rec_valid && !rec_write && rec_jtag && (cyc == rec_t + 2 + L);
        if (exp_cv) m_cpu_hold = rec_data;
        if (exp_jv) m_jtag_hold = rec_data;

        chk("waitrequest", 32'(cpu_waitrequest), 32'(reset || !cgnt));
        chk("ram_wren", 32'(ram_wren), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", 32'(ram_addr), 32'(rec_addr));
            chk("wr_byteen", 32'(ram_byteen), 32'(rec_be));
            chk("wr_data", ram_wdata, rec_data);
            waddr_q.push_back(ram_addr);
        end
        if (exp_rdi) begin
            chk("rd_addr", 32'(ram_addr), 32'(rec_addr));
            if (rec_jtag) jaddr_q.push_back(ram_addr);
        end
        chk("cpu_rdv", 32'(cpu_readdatavalid), 32'(exp_cv));
        chk("cpu_rdata", cpu_readdata, m_cpu_hold);
        chk("jtag_rdv", 32'(jtag_rdata_valid), 32'(exp_jv));
        chk("jtag_rdata", jtag_rdata, m_jtag_hold);
        chk("jtag_busy", 32'(jtag_busy), 32'(busy));
        chk("jtag_overrun", 32'(jtag_overrun), 32'(m_ov));

        if (jtag_rdata_valid === 1'b1) begin
            jq.push_back(jtag_rdata);
            jlat_q.push_back(cyc - m_last_jgnt);
        end
        if (cpu_readdatavalid === 1'b1) begin
            cq.push_back(cpu_readdata);
            cpv_cnt++;
        end
        if (!reset && cpu_waitrequest === 1'b0) wr_low_cnt++;

        if (reset) begin
            free_at = cyc + 1; rec_valid = 0; m_pend = 0; m_ptr = '0;
            m_run = 0; m_ov = 0; m_cpu_hold = '0; m_jtag_hold = '0;
        end else begin
            eff = jtag_set_addr ? jtag_addr : m_ptr;
            if (cgnt) begin
                rec_valid = 1; rec_t = cyc; rec_jtag = 0; rec_write = cpu_write;
                rec_addr = cpu_address; rec_be = cpu_byteenable;
                if (cpu_write) begin
                    rec_data = cpu_writedata;
                    for (int b = 0; b < 4; b++)
                        if (cpu_byteenable[b]) shadow[cpu_address][8*b +: 8] = cpu_writedata[8*b +: 8];
                end else begin
                    rec_data = shadow[cpu_address];
                end
                free_at = cyc + (cpu_write ? 2 : 2 + L);
                glog.push_back(8'h43);
            end else if (jgnt) begin
                rec_valid = 1; rec_t = cyc; rec_jtag = 1; rec_write = m_pend_wr;
                rec_addr = eff; rec_be = 4'hF;
                if (m_pend_wr) begin
                    rec_data = m_pend_wdata;
                    shadow[eff] = m_pend_wdata;
                end else begin
                    rec_data = shadow[eff];
                end
                free_at = cyc + (m_pend_wr ? 2 : 2 + L);
                m_last_jgnt = cyc;
                glog.push_back(8'h4A);
            end
            if (!m_pend || jgnt) m_run = 0;
            else if (cgnt)       m_run = m_run + 1;
            m_ptr = jgnt ? eff + 8'd1 : eff;
            ovt = jtag_set_addr ? 1'b0 : m_ov;
            if ((jtag_rd || jtag_wr) && busy) ovt = 1'b1;
            if (jtag_rd && jtag_wr) ovt = 1'b1;
            m_ov = ovt;
            if (jgnt) m_pend = 0;
            if ((jtag_rd || jtag_wr) && !busy) begin
                m_pend = 1; m_pend_wr = jtag_wr; m_pend_wdata = jtag_wdata;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic jtag_pulse(input bit s, input logic [7:0] a, input bit r,
                              input bit w, input logic [31:0] d);
        jtag_set_addr = s; jtag_addr = a; jtag_rd = r; jtag_wr = w; jtag_wdata = d;
        tick();
        jtag_set_addr = 0; jtag_rd = 0; jtag_wr = 0;
    endtask

    task automatic wait_jtag_idle();
        int n = 0;
        while (jtag_busy !== 1'b0 && n < 200) begin tick(); n++; end
        if (n >= 200) chk("jtag_idle_timeout", 32'(jtag_busy), 32'h0);
        tick();
    endtask

    task automatic cpu_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        int n = 0;
        cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
        cpu_write = wr; cpu_read = !wr;
        @(negedge clk);
        while (cpu_waitrequest !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("cpu_accept_timeout", 32'(cpu_waitrequest), 32'h0);
        @(posedge clk); #1;
        cpu_read = 0; cpu_write = 0;
    endtask

    initial begin
        int n, wl0, cp0;
        string fair;
        repeat (3) tick();
        chk("reset_waitreq", 32'(cpu_waitrequest), 32'h1);
        reset = 0;
        tick();
        chk("reset_rdata", jtag_rdata, 32'h0);

        // JTAG write then read-back with auto-increment
        jtag_pulse(1, 8'h10, 0, 0, 0);
        jtag_pulse(0, 0, 0, 1, 32'hDEADBEEF); wait_jtag_idle();
        jtag_pulse(0, 0, 0, 1, 32'h12345678); wait_jtag_idle();
        jtag_pulse(1, 8'h10, 0, 0, 0);
        jq.delete(); jlat_q.delete();
        jtag_pulse(0, 0, 1, 0, 0); wait_jtag_idle();
        jtag_pulse(0, 0, 1, 0, 0); wait_jtag_idle();
        chk("rb_first", jq[0], 32'hDEADBEEF);
        chk("rb_second", jq[1], 32'h12345678);
        chk("rb_lat0", 32'(jlat_q[0]), 32'd4);
        chk("rb_lat1", 32'(jlat_q[1]), 32'd4);
        chk("model_ptr", 32'(m_ptr), 32'h12);
        jtag_pulse(0, 0, 1, 0, 0); wait_jtag_idle();
        chk("ptr_next_rd", 32'(jaddr_q[$]), 32'h12);

        // CPU byte-enabled write and read-back
        wl0 = wr_low_cnt;
        cpu_xfer(1, 8'h20, 32'hA5A5A5A5, 4'b0011);
        cpu_xfer(0, 8'h20, 0, 4'hF);
        repeat (6) tick();
        chk("cpu_rb", cq[$], 32'h0000A5A5);
        chk("waitreq_low_cycles", 32'(wr_low_cnt - wl0), 32'd2);

        // Fairness: continuous CPU reads with a JTAG read pending
        glog.delete();
        cpu_address = 8'h30; cpu_byteenable = 4'hF; cpu_read = 1;
        tick();
        jtag_pulse(0, 0, 1, 0, 0);
        n = 0;
        while (glog.size() < 7 && n < 300) begin tick(); n++; end
        cpu_read = 0;
        if (n >= 300) chk("fair_timeout", 32'(glog.size()), 32'd7);
        fair = "CCCCCJC";
        for (int i = 0; i < 7 && i < glog.size(); i++)
            chk("fair_seq", 32'(glog[i]), 32'(fair[i]));
        repeat (8) tick();
        chk("model_run_cleared", 32'(m_run), 32'd0);

        // Pointer wrap
        jtag_pulse(1, 8'hFF, 0, 0, 0);
        jtag_pulse(0, 0, 1, 0, 0); wait_jtag_idle();
        jtag_pulse(0, 0, 1, 0, 0); wait_jtag_idle();
        chk("wrap_a", 32'(jaddr_q[$-1]), 32'hFF);
        chk("wrap_b", 32'(jaddr_q[$]), 32'h00);

        // Overrun: strobes while the first read is pending/in flight
        glog.delete();
        jtag_pulse(0, 0, 1, 0, 0);
        jtag_pulse(0, 0, 1, 0, 0);
        tick();
        jtag_pulse(0, 0, 1, 0, 0);
        wait_jtag_idle();
        chk("ovr_one_grant", 32'(glog.size()), 32'd1);
        chk("ovr_set", 32'(jtag_overrun), 32'h1);
        jtag_pulse(1, 8'h00, 0, 0, 0);
        chk("ovr_cleared", 32'(jtag_overrun), 32'h0);

        // set_addr together with a write strobe
        jtag_pulse(1, 8'h40, 0, 1, 32'h1); wait_jtag_idle();
        chk("sa_wr_addr", 32'(waddr_q[$]), 32'h40);
        jtag_pulse(0, 0, 1, 0, 0); wait_jtag_idle();
        chk("sa_ptr", 32'(jaddr_q[$]), 32'h41);

        // Reset in RD_WAIT
        cp0 = cpv_cnt;
        cpu_xfer(0, 8'h20, 0, 4'hF);
        tick();
        reset = 1; cpu_read = 1;
        tick();
        chk("rst_waitreq", 32'(cpu_waitrequest), 32'h1);
        tick();
        reset = 0; cpu_read = 0;
        repeat (8) tick();
        chk("rst_no_valid", 32'(cpv_cnt), 32'(cp0));
        cpu_xfer(0, 8'h20, 0, 4'hF);
        repeat (6) tick();
        chk("rst_then_read", cq[$], 32'h0000A5A5);

        // Randomized mix of both requesters
        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    cpu_xfer(1'($urandom_range(0, 1)), 8'(32'h20 + $urandom_range(0, 15)),
                             $urandom, 4'($urandom_range(1, 15)));
                end
            end
            begin
                for (int k = 0; k < 1500; k++) begin
                    int r, r2;
                    r  = $urandom_range(0, 99);
                    r2 = $urandom_range(0, 19);
                    jtag_set_addr = (r < 8);
                    jtag_addr     = (r2 < 16) ? 8'(32'h20 + r2) : 8'(32'hFC + r2 - 16);
                    jtag_rd       = (r >= 8 && r < 22) || (r >= 97);
                    jtag_wr       = (r >= 22 && r < 32) || (r >= 97);
                    jtag_wdata    = $urandom;
                    tick();
                end
                jtag_set_addr = 0; jtag_rd = 0; jtag_wr = 0;
            end
        join
        wait_jtag_idle();
        repeat (10) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/debug_ocimem_arbiter.md
Name: debug_ocimem_arbiter

Overview:
Arbitrates single-port access to the on-chip debug memory (OCI RAM) between two requesters: the JTAG debug-slave path (sysclk-side take_action strobes with jdo-derived address/data) and the CPU's Avalon debug_mem_slave.
- Holds the JTAG auto-incrementing address pointer.
- Allows one access in flight at a time and returns read data to the requester that issued it.
- Enforces bounded fairness so that neither requester starves.

Parameters:
ADDR_W, 8, OCI RAM word-address width.
DATA_W, 32, data width.
RAM_LATENCY, 2, RAM read latency in cycles from ram_addr presented to ram_rdata valid (range 1..4).
MAX_CPU_RUN, 4, maximum consecutive CPU grants while a JTAG request is pending.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jtag_set_addr  in  1  pulse: load JTAG pointer from jtag_addr
jtag_addr  in  ADDR_W  new pointer value
jtag_rd  in  1  pulse: read at pointer
jtag_wr  in  1  pulse: write jtag_wdata at pointer
jtag_wdata  in  DATA_W  JTAG write data
jtag_rdata  out  DATA_W  last JTAG read result (MonDReg source)
jtag_rdata_valid  out  1  one-cycle pulse
jtag_busy  out  1  JTAG request pending or in flight
jtag_overrun  out  1  sticky: JTAG strobe dropped
cpu_address  in  ADDR_W  Avalon address
cpu_read  in  1  Avalon read
cpu_write  in  1  Avalon write
cpu_writedata  in  DATA_W  Avalon write data
cpu_byteenable  in  DATA_W/8  Avalon byte enables
cpu_waitrequest  out  1  Avalon waitrequest
cpu_readdata  out  DATA_W  Avalon read data
cpu_readdatavalid  out  1  one-cycle pulse
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_byteen  out  DATA_W/8  RAM byte enables
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset values: all registered outputs 0, jtag pointer 0, run counter 0, FSM IDLE; cpu_waitrequest=1 during reset.
- JTAG pending register, one deep: jtag_rd or jtag_wr captured as op + wdata.
  - A strobe arriving while an op is pending or in flight is dropped and sets jtag_overrun.
  - jtag_rd and jtag_wr in the same cycle: write is captured, read is dropped, overrun is set.
  - jtag_set_addr clears overrun. A set_addr in the same cycle as a rd/wr strobe updates the pointer first, so the access uses the new address.
  - A set_addr while an op is pending retargets that op.
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_RET.
- Grant decision in IDLE only (combinational, cycle T):
  - If both requesters want access, CPU wins unless run_cnt==MAX_CPU_RUN, in which case JTAG wins.
  - If only one requester wants access, it wins.
  - run_cnt increments on each CPU grant made while JTAG is pending; it clears on a JTAG grant or when JTAG is not pending.
- cpu_waitrequest = ~(IDLE & CPU granted). It is high in all other states.
- Write: at T+1 (WR_ISSUE) ram_addr, ram_wren=1, ram_byteen and ram_wdata are driven for exactly one cycle. JTAG writes use byteen all-ones. IDLE resumes at T+2.
- Read: RD_ISSUE at T+1 drives ram_addr with ram_wren=0. RD_WAIT counts RAM_LATENCY-1 cycles. ram_rdata is sampled at T+1+RAM_LATENCY. At T+2+RAM_LATENCY, cpu_readdata+cpu_readdatavalid (or jtag_rdata+jtag_rdata_valid) are presented for one cycle and the FSM is in IDLE, so a new grant can occur in that same cycle.
- jtag_rdata holds its value until the next JTAG read completes. cpu_readdata holds likewise.
- JTAG pointer increments by 1 after each JTAG grant and wraps from 2^ADDR_W-1 to 0.
- jtag_busy = pending | JTAG op in flight.
- ram_wren is 0 in every state except WR_ISSUE. The ram_* address and data outputs hold their last value otherwise.
- Reset mid-operation: FSM returns to IDLE, the pending op is discarded, no valid pulse is issued, and no further ram_wren is driven.

Test Plan:
- JTAG write/read-back: set_addr 0x10; wr 0xDEADBEEF; wr 0x12345678; set_addr 0x10; rd; rd -> jtag_rdata 0xDEADBEEF then 0x12345678; valid pulses 2+RAM_LATENCY cycles after each grant; pointer ends at 0x12.
- CPU Avalon: write 0xA5A5A5A5 byteenable 4'b0011 to addr 0x20, then read 0x20 (RAM preloaded 0) -> readdata 0x0000A5A5; waitrequest low exactly one cycle per transfer.
- Fairness: CPU reads continuous while JTAG rd pending -> exactly 4 CPU grants, then the JTAG grant, then CPU resumes; run_cnt back to 0.
- Wrap/overrun: set_addr 0xFF; rd; rd -> second read at 0x00. Two rd strobes one cycle apart while the first is in flight -> jtag_overrun=1, one read issued; set_addr clears the flag.
- Simultaneous set_addr 0x40 + wr 0x1 while idle -> RAM write at 0x40, pointer 0x41.
- Reset asserted in RD_WAIT -> no readdatavalid, ram_wren stays 0, cpu_waitrequest=1 during reset, IDLE afterwards; a subsequent CPU read succeeds.
